seq_mul: RTL and testbench

Iterative shift-add multiplier with a valid/ready handshake; parametrised successor to the combinational array multiplier.
- Processes RADIX_BITS multiplier bits per clock, so width and latency trade against area.
- Supports unsigned and two's-complement signed operands, selected per transaction.
- Used where a full N×N combinational array is too large or too slow for the ALU datapath.

---
 rtl/seq_mul.sv | 177 +++++++++++++++++
 tb/tb_seq_mul.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mul.sv
// Iterative shift-add multiplier: retires RADIX_BITS multiplier bits per clock
// behind a valid/ready handshake, with per-transaction signed/unsigned selection.
module seq_mul #(
    parameter int N          = 16,
    parameter int RADIX_BITS = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           in_signed,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] O,
    output logic           busy
);

    localparam int PW     = 2 * N;
    localparam int STEPS  = N / RADIX_BITS;
    localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    generate
        if ((N < 2) || !((RADIX_BITS == 1) || (RADIX_BITS == 2) || (RADIX_BITS == 4)) ||
            ((N % RADIX_BITS) != 0)) begin : g_bad_params
            $error("seq_mul: illegal N/RADIX_BITS combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Magnitude of an operand; the most-negative value maps onto 2^(N-1) unchanged.
    function automatic logic [N-1:0] magnitude(input logic [N-1:0] v, input logic sgn);
        logic [N-1:0] r;
        if (sgn && v[N-1]) begin
            r = ~v + {{(N-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

    function automatic logic [PW-1:0] apply_sign(input logic [PW-1:0] v, input logic neg);
        logic [PW-1:0] r;
        if (neg) begin
            r = ~v + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

    state_e             state_q, state_d;
    logic [N-1:0]       mcand_q, mcand_d;
    logic [N-1:0]       mplier_q, mplier_d;
    logic [PW-1:0]      acc_q, acc_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic               neg_q, neg_d;
    logic [PW-1:0]      o_q, o_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q, in_ready_d;
    logic               busy_q, busy_d;

    logic [RADIX_BITS-1:0] digit_s;
    logic [PW-1:0]         pp_s;
    logic [PW-1:0]         pp_shift_s;
    logic [PW-1:0]         sum_s;
    logic                  last_step_s;

    // Partial product of the current multiplier digit, aligned to its bit weight.
    always_comb begin
        digit_s     = mplier_q[RADIX_BITS-1:0];
        pp_s        = PW'(mcand_q) * PW'(digit_s);
        pp_shift_s  = pp_s << (step_q * RADIX_BITS);
        sum_s       = acc_q + pp_shift_s;
        last_step_s = (step_q == STEP_W'(STEPS - 1));
    end

    // Next-state and next-register logic for the IDLE/BUSY/DONE controller.
    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        step_d      = step_q;
        neg_d       = neg_q;
        o_d         = o_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        busy_d      = busy_q;

        case (state_q)
            ST_IDLE: begin
                in_ready_d = 1'b1;
                if (in_valid) begin
                    mcand_d    = magnitude(A, in_signed);
                    mplier_d   = magnitude(B, in_signed);
                    neg_d      = in_signed & (A[N-1] ^ B[N-1]);
                    acc_d      = {PW{1'b0}};
                    step_d     = {STEP_W{1'b0}};
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                acc_d    = sum_s;
                mplier_d = mplier_q >> RADIX_BITS;
                step_d   = step_q + STEP_W'(1);
                // Latency is fixed: no early exit even when the remaining multiplier is zero.
                if (last_step_s) begin
                    o_d         = apply_sign(sum_s, neg_q);
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                busy_d      = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mcand_q     <= {N{1'b0}};
            mplier_q    <= {N{1'b0}};
            acc_q       <= {PW{1'b0}};
            step_q      <= {STEP_W{1'b0}};
            neg_q       <= 1'b0;
            o_q         <= {PW{1'b0}};
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            step_q      <= step_d;
            neg_q       <= neg_d;
            o_q         <= o_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign O         = o_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_seq_mul.sv
// Scoreboard bench for seq_mul: five instances with different N/RADIX_BITS,
// expected products from an arithmetic reference model, checked by a monitor.
module tb_seq_mul;

    localparam int NDUT = 5;
    localparam int NR   = 2000;

    typedef struct packed {
        logic [63:0] prod;
        logic [31:0] cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid_s  [NDUT];
    logic        in_ready_s  [NDUT];
    logic        in_signed_s [NDUT];
    logic [31:0] a_s         [NDUT];
    logic [31:0] b_s         [NDUT];
    logic        out_valid_s [NDUT];
    logic        out_ready_s [NDUT];
    logic        busy_s      [NDUT];
    logic [63:0] o_s         [NDUT];
    logic [31:0] o0, o1, o3;
    logic [15:0] o2;
    logic [63:0] o4;

    exp_t        exp_q [NDUT][$];
    int unsigned cyc;
    int          n_cmp;
    int          n_fail;
    bit          hs_prev  [NDUT];
    bit          ov_prev  [NDUT];
    bit          rand_done[NDUT];

    seq_mul #(.N(16), .RADIX_BITS(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
        .in_signed(in_signed_s[0]), .A(a_s[0][15:0]), .B(b_s[0][15:0]),
        .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]), .O(o0), .busy(busy_s[0]));
    seq_mul #(.N(16), .RADIX_BITS(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
        .in_signed(in_signed_s[1]), .A(a_s[1][15:0]), .B(b_s[1][15:0]),
        .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]), .O(o1), .busy(busy_s[1]));
    seq_mul #(.N(8), .RADIX_BITS(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[2]), .in_ready(in_ready_s[2]),
        .in_signed(in_signed_s[2]), .A(a_s[2][7:0]), .B(b_s[2][7:0]),
        .out_valid(out_valid_s[2]), .out_ready(out_ready_s[2]), .O(o2), .busy(busy_s[2]));
    seq_mul #(.N(16), .RADIX_BITS(2)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[3]), .in_ready(in_ready_s[3]),
        .in_signed(in_signed_s[3]), .A(a_s[3][15:0]), .B(b_s[3][15:0]),
        .out_valid(out_valid_s[3]), .out_ready(out_ready_s[3]), .O(o3), .busy(busy_s[3]));
    seq_mul #(.N(32), .RADIX_BITS(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[4]), .in_ready(in_ready_s[4]),
        .in_signed(in_signed_s[4]), .A(a_s[4]), .B(b_s[4]),
        .out_valid(out_valid_s[4]), .out_ready(out_ready_s[4]), .O(o4), .busy(busy_s[4]));

    assign o_s[0] = {32'd0, o0};
    assign o_s[1] = {32'd0, o1};
    assign o_s[2] = {48'd0, o2};
    assign o_s[3] = {32'd0, o3};
    assign o_s[4] = o4;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int n_of(input int i);
        case (i)
            0: return 16;
            1: return 16;
            2: return 8;
            3: return 16;
            default: return 32;
        endcase
    endfunction

    function automatic int r_of(input int i);
        case (i)
            0: return 1;
            1: return 4;
            2: return 1;
            3: return 2;
            default: return 4;
        endcase
    endfunction

    // Reference: true integer product of the interpreted operands, reduced to 2N bits.
    function automatic logic [63:0] model(input int i, input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
        int          n = n_of(i);
        longint      sa, sb;
        logic [63:0] p, m;
        sa = longint'({32'd0, a});
        sb = longint'({32'd0, b});
        if (s && a[n-1]) sa = sa - (longint'(1) << n);
        if (s && b[n-1]) sb = sb - (longint'(1) << n);
        p = 64'(sa * sb);
        m = (n == 32) ? {64{1'b1}} : ((64'd1 << (2 * n)) - 64'd1);
        return p & m;
    endfunction

    function automatic logic [31:0] rnd_op(input int n);
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0: v = 32'd0;
            1: v = 32'hFFFF_FFFF;
            2: v = 32'd1 << (n - 1);
            3: v = 32'd1;
            default: v = $urandom;
        endcase
        if (n < 32) v = v & ((32'd1 << n) - 32'd1);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [63:0] expv);
        int t   = 0;
        bit got = 1'b0;
        a_s[i] = a; b_s[i] = b; in_signed_s[i] = s; in_valid_s[i] = 1'b1;
        while (!got && t < 400) begin
            @(negedge clk);
            if (in_ready_s[i]) begin
                exp_q[i].push_back('{prod: expv, cyc: cyc + 1});
                got = 1'b1;
            end
            t++;
        end
        if (!got) chk($sformatf("accept_timeout[%0d]", i), 64'd0, 64'd1);
        @(posedge clk); #1;
        in_valid_s[i]  = 1'b0;
        in_signed_s[i] = ~s;
        a_s[i]         = $urandom;
        b_s[i]         = $urandom;
    endtask

    task automatic drain(input int i);
        int t = 0;
        while (exp_q[i].size() != 0 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (exp_q[i].size() != 0) chk($sformatf("drain_timeout[%0d]", i), 64'd0, 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic rand_drive(input int i);
        logic [31:0] a, b;
        logic        s;
        int          n = n_of(i);
        for (int k = 0; k < NR; k++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            a = rnd_op(n);
            b = rnd_op(n);
            s = 1'($urandom_range(0, 1));
            issue(i, a, b, s, model(i, a, b, s));
        end
        drain(i);
        rand_done[i] = 1'b1;
    endtask

    task automatic rdy_toggle(input int i);
        while (!rand_done[i]) begin
            @(posedge clk); #1;
            out_ready_s[i] = ($urandom_range(0, 3) != 0);
        end
        out_ready_s[i] = 1'b1;
    endtask

    // Monitor: latency and handshake checks, pops the scoreboard on each output transfer.
    always @(negedge clk) begin
        for (int i = 0; i < NDUT; i++) begin
            if (!rst_n) begin
                hs_prev[i] = 1'b0;
                ov_prev[i] = 1'b0;
            end else begin
                if (hs_prev[i]) chk($sformatf("in_ready_after_hs[%0d]", i), 64'(in_ready_s[i]), 64'd1);
                hs_prev[i] = 1'b0;
                if (out_valid_s[i] && !ov_prev[i]) begin
                    if (exp_q[i].size() == 0) begin
                        chk($sformatf("spurious_out_valid[%0d]", i), 64'd1, 64'd0);
                    end else begin
                        chk($sformatf("latency[%0d]", i), 64'(cyc - exp_q[i][0].cyc),
                            64'(n_of(i) / r_of(i)));
                        chk($sformatf("in_ready_in_done[%0d]", i), 64'(in_ready_s[i]), 64'd0);
                        chk($sformatf("busy_in_done[%0d]", i), 64'(busy_s[i]), 64'd1);
                    end
                end
                if (out_valid_s[i] && out_ready_s[i]) begin
                    if (exp_q[i].size() == 0) begin
                        chk($sformatf("unexpected_output[%0d]", i), 64'd1, 64'd0);
                    end else begin
                        chk($sformatf("O[%0d]", i), o_s[i], exp_q[i].pop_front().prod);
                    end
                    hs_prev[i] = 1'b1;
                end
                ov_prev[i] = out_valid_s[i];
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw_ov;
        n_cmp = 0;
        n_fail = 0;
        cyc = 0;
        rst_n = 1'b0;
        for (int i = 0; i < NDUT; i++) begin
            in_valid_s[i] = 1'b0; in_signed_s[i] = 1'b0; a_s[i] = 32'd0; b_s[i] = 32'd0;
            out_ready_s[i] = 1'b0; rand_done[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NDUT; i++) begin
            chk($sformatf("rst_in_ready[%0d]", i), 64'(in_ready_s[i]), 64'd1);
            chk($sformatf("rst_out_valid[%0d]", i), 64'(out_valid_s[i]), 64'd0);
            chk($sformatf("rst_busy[%0d]", i), 64'(busy_s[i]), 64'd0);
            chk($sformatf("rst_O[%0d]", i), o_s[i], 64'd0);
        end
        @(posedge clk); #1;

        out_ready_s[0] = 1'b1;
        out_ready_s[1] = 1'b1;
        issue(0, 32'h0003, 32'h0005, 1'b0, 64'h0000_000F);
        drain(0);
        issue(1, 32'hFFFF, 32'hFFFF, 1'b0, 64'hFFFE_0001);
        drain(1);
        issue(0, 32'hFFFD, 32'h0007, 1'b1, 64'hFFFF_FFEB);
        drain(0);
        issue(0, 32'h8000, 32'h8000, 1'b1, 64'h4000_0000);
        drain(0);
        issue(0, 32'h8000, 32'h0001, 1'b1, 64'hFFFF_8000);
        drain(0);
        issue(1, 32'h8000, 32'h8000, 1'b1, 64'h4000_0000);
        drain(1);

        // Backpressure: result must hold while the consumer stalls and inputs churn.
        out_ready_s[0] = 1'b0;
        issue(0, 32'h1234, 32'h5678, 1'b0, 64'h0626_0060);
        begin
            int t = 0;
            while (!out_valid_s[0] && t < 100) begin
                @(negedge clk);
                t++;
            end
            chk("bp_out_valid_rise", 64'(out_valid_s[0]), 64'd1);
        end
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            a_s[0] = $urandom; b_s[0] = $urandom;
            in_valid_s[0] = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("bp_O_stable", o_s[0], 64'h0626_0060);
            chk("bp_in_ready", 64'(in_ready_s[0]), 64'd0);
            chk("bp_out_valid", 64'(out_valid_s[0]), 64'd1);
        end
        @(posedge clk); #1;
        in_valid_s[0]  = 1'b0;
        out_ready_s[0] = 1'b1;
        drain(0);

        // Asynchronous reset in the middle of a BUSY phase.
        issue(0, 32'hFFFF, 32'hFFFF, 1'b0, 64'hFFFE_0001);
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", 64'(out_valid_s[0]), 64'd0);
        chk("rst_mid_O", o_s[0], 64'd0);
        chk("rst_mid_busy", 64'(busy_s[0]), 64'd0);
        chk("rst_mid_in_ready", 64'(in_ready_s[0]), 64'd1);
        exp_q[0].delete();
        @(posedge clk); #1 rst_n = 1'b1;
        saw_ov = 1'b0;
        repeat (30) begin
            @(negedge clk);
            saw_ov = saw_ov | out_valid_s[0];
        end
        chk("no_out_valid_after_reset", 64'(saw_ov), 64'd0);

        fork
            rand_drive(2);
            rand_drive(3);
            rand_drive(4);
            rdy_toggle(2);
            rdy_toggle(3);
            rdy_toggle(4);
        join

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
